// File: rtl/seq_match_window_counter_pkg.sv
// Shared definitions for the match window counter: FSM state encoding
// and the default window/count geometry.
package seq_match_window_counter_pkg;

  typedef enum logic {
    ST_IDLE  = 1'b0,
    ST_COUNT = 1'b1
  } state_e;

  localparam int DEF_WIN_LEN = 16;
  localparam int DEF_CNT_W   = 5;

endpackage : seq_match_window_counter_pkg

// File: rtl/seq_match_window_counter.sv
// Counts one-cycle match flags from the sequence detector over fixed windows
// of WIN_LEN cycles and publishes each window's saturated count through a
// valid/ready output register. Unconsumed results are overwritten and flagged.
module seq_match_window_counter
  import seq_match_window_counter_pkg::*;
#(
  parameter int WIN_LEN = DEF_WIN_LEN,
  parameter int CNT_W   = DEF_CNT_W
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             z,
  input  logic             en,
  input  logic             out_ready,
  output logic             out_valid,
  output logic [CNT_W-1:0] out_count,
  output logic             out_ovr,
  output logic             busy
);

  localparam int IDX_W = $clog2(WIN_LEN);

  state_e             r_state;
  logic [IDX_W-1:0]   r_win_idx;
  logic [CNT_W-1:0]   r_cnt;
  logic               r_busy;
  logic               r_out_valid;
  logic [CNT_W-1:0]   r_out_count;
  logic               r_out_ovr;

  logic [CNT_W-1:0]   w_cnt_max;
  logic [CNT_W-1:0]   w_sum;
  logic               w_last;
  logic               w_capture;
  logic               w_transfer;

  // Saturating running count including this cycle's match flag.
  assign w_cnt_max  = '1;
  assign w_sum      = (r_cnt == w_cnt_max) ? r_cnt : r_cnt + CNT_W'(z);
  assign w_last     = (r_win_idx == IDX_W'(WIN_LEN - 1));
  assign w_capture  = (r_state == ST_COUNT) && en && w_last;
  assign w_transfer = r_out_valid && out_ready;

  // Window FSM, match counter and output register with valid/ready handshake.
  // NOTE: sequential state uses non-blocking assignments so every register
  // samples the pre-edge values of the others, matching hardware behaviour.
  always_ff @(posedge clk) begin
    if (!reset) begin
      r_state     <= ST_IDLE;
      r_win_idx   <= '0;
      r_cnt       <= '0;
      r_busy      <= 1'b0;
      r_out_valid <= 1'b0;
      r_out_count <= '0;
      r_out_ovr   <= 1'b0;
    end else begin
      unique case (r_state)
        ST_IDLE: begin
          if (en) begin
            // This cycle is sample 0 of the new window.
            r_state   <= ST_COUNT;
            r_busy    <= 1'b1;
            r_win_idx <= IDX_W'(1);
            r_cnt     <= CNT_W'(z);
          end
        end
        ST_COUNT: begin
          if (!en) begin
            // Abort: discard the partial window, leave the result untouched.
            r_state   <= ST_IDLE;
            r_busy    <= 1'b0;
            r_win_idx <= '0;
            r_cnt     <= '0;
          end else if (w_last) begin
            // Back-to-back: next window's sample 0 is the following cycle.
            r_win_idx <= '0;
            r_cnt     <= '0;
          end else begin
            r_win_idx <= r_win_idx + IDX_W'(1);
            r_cnt     <= w_sum;
          end
        end
        default: begin
          r_state <= ST_IDLE;
          r_busy  <= 1'b0;
        end
      endcase

      // A capture wins over a concurrent transfer and keeps out_valid high.
      if (w_capture) begin
        r_out_valid <= 1'b1;
        r_out_count <= w_sum;
        r_out_ovr   <= r_out_valid && !out_ready;
      end else if (w_transfer) begin
        r_out_valid <= 1'b0;
      end
    end
  end

  assign out_valid = r_out_valid;
  assign out_count = r_out_count;
  assign out_ovr   = r_out_ovr;
  assign busy      = r_busy;

endmodule : seq_match_window_counter
